// File: rtl/pe_stream_pkg.sv
// pe_stream_feeder shared types.
// State encoding, width defaults, issue-period helper.
package pe_stream_pkg;

  localparam int II_WIDTH_DEF  = 4;
  localparam int CNT_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  // An II of zero is meaningless; run it as back-to-back.
  function automatic int unsigned period_of(
    input int unsigned ii
  );
    return (ii == 0) ? 32'd1 : ii;
  endfunction

endpackage

// File: rtl/stream_fifo.sv
// Small synchronous FIFO for the stream feeder.
// Registered ready, count-based full/empty.
module stream_fifo #(
  parameter int size  = 32,
  parameter int DEPTH = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic [size-1:0] wdata,
  input  logic            pop,
  output logic [size-1:0] rdata,
  output logic            empty,
  output logic            ready
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0]   wp_q, wp_d;
  logic [AW-1:0]   rp_q, rp_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic            rdy_q, rdy_d;
  logic            do_push;
  logic            do_pop;
  logic [size-1:0] mem_q [DEPTH];

  assign empty = (cnt_q == '0);
  assign ready = rdy_q;
  assign rdata = mem_q[rp_q];

  // Pointer/occupancy update; ready looks at next occupancy.
  always_comb begin
    do_push = push && rdy_q;
    do_pop  = pop && !empty;
    wp_d    = do_push ? wp_q + 1'b1 : wp_q;
    rp_d    = do_pop ? rp_q + 1'b1 : rp_q;
    cnt_d   = cnt_q;
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!do_push && do_pop) begin
      cnt_d = cnt_q - 1'b1;
    end
    rdy_d = (cnt_d != FULL_CNT);
  end

  // Control state; ready held low through reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      rdy_q <= 1'b0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
      rdy_q <= rdy_d;
    end
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wp_q] <= wdata;
    end
  end

endmodule

// File: rtl/pe_stream_feeder.sv
// Fixed-II stream feeder in front of a PE input.
// FIFO-buffered, stalls and flags underrun on starvation.
module pe_stream_feeder
  import pe_stream_pkg::*;
#(
  parameter int size      = 32,
  parameter int DEPTH     = 8,
  parameter int II_WIDTH  = II_WIDTH_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [size-1:0]      in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 start,
  input  logic [II_WIDTH-1:0]  ii,
  input  logic [CNT_WIDTH-1:0] count,
  output logic [size-1:0]      out0,
  output logic                 out_valid,
  output logic                 busy,
  output logic                 done,
  output logic                 underrun
);

  state_e               state_q, state_d;
  logic [II_WIDTH-1:0]  period_q, period_d;
  logic [II_WIDTH-1:0]  slot_q, slot_d;
  logic [CNT_WIDTH-1:0] rem_q, rem_d;
  logic [size-1:0]      out0_q, out0_d;
  logic                 ov_q, ov_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 und_q, und_d;
  logic                 pop;
  logic                 f_empty;
  logic [size-1:0]      f_rdata;

  stream_fifo #(
    .size  (size),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (in_valid),
    .wdata (in_data),
    .pop   (pop),
    .rdata (f_rdata),
    .empty (f_empty),
    .ready (in_ready)
  );

  assign out0      = out0_q;
  assign out_valid = ov_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign underrun  = und_q;

  // Next-state: start latch, slot countdown, issue or stall.
  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    slot_d   = slot_q;
    rem_d    = rem_q;
    out0_d   = out0_q;
    und_d    = und_q;
    ov_d     = 1'b0;
    pop      = 1'b0;
    busy_d   = (state_q != ST_IDLE);
    done_d   = (state_q == ST_DONE);
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          period_d = II_WIDTH'(period_of(32'(ii)));
          rem_d    = count;
          und_d    = 1'b0;
          slot_d   = '0;
          state_d  = (count == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (slot_q == '0) begin
          if (!f_empty) begin
            pop    = 1'b1;
            out0_d = f_rdata;
            ov_d   = 1'b1;
            rem_d  = rem_q - 1'b1;
            slot_d = period_q - 1'b1;
            if (rem_q == CNT_WIDTH'(1)) begin
              state_d = ST_DONE;
            end
          end else begin
            und_d = 1'b1;
          end
        end else begin
          slot_d = slot_q - 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      period_q <= '0;
      slot_q   <= '0;
      rem_q    <= '0;
      out0_q   <= '0;
      ov_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      und_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      slot_q   <= slot_d;
      rem_q    <= rem_d;
      out0_q   <= out0_d;
      ov_q     <= ov_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      und_q    <= und_d;
    end
  end

endmodule

// File: tb/tb_pe_stream_feeder.sv
// Self-checking bench for pe_stream_feeder.
// Time-based reference model plus scenario tasks.
module tb_pe_stream_feeder;

  localparam int W   = 32;
  localparam int D   = 8;
  localparam int IIW = 4;
  localparam int CW  = 16;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [W-1:0]   in_data = '0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic           start = 1'b0;
  logic [IIW-1:0] ii = '0;
  logic [CW-1:0]  count = '0;
  logic [W-1:0]   out0;
  logic           out_valid;
  logic           busy;
  logic           done;
  logic           underrun;

  int tests = 0;
  int fails = 0;

  pe_stream_feeder #(
    .size      (W),
    .DEPTH     (D),
    .II_WIDTH  (IIW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .start     (start),
    .ii        (ii),
    .count     (count),
    .out0      (out0),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done),
    .underrun  (underrun)
  );

  always #5 clk = ~clk;

  // Reference model: word queue plus absolute slot times.
  logic [W-1:0] mq[$];
  longint       cyc;
  longint       m_next;
  longint       m_done_at;
  bit           m_active;
  int           m_per;
  int           m_rem;
  logic [W-1:0] m_out0;
  logic         m_ov, m_done, m_busy, m_und, m_rdy;
  bit           act_pre, rdy_pre;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      cyc       = 0;
      m_next    = 0;
      m_done_at = -1;
      m_active  = 0;
      m_per     = 1;
      m_rem     = 0;
      m_out0    = '0;
      m_ov      = 0;
      m_done    = 0;
      m_busy    = 0;
      m_und     = 0;
      m_rdy     = 0;
    end else begin
      cyc++;
      act_pre = m_active;
      rdy_pre = m_rdy;
      m_ov    = 0;
      if (act_pre) begin
        if (cyc >= m_next) begin
          if (mq.size() > 0) begin
            m_out0 = mq.pop_front();
            m_ov   = 1;
            m_rem--;
            m_next = cyc + m_per;
            if (m_rem == 0) begin
              m_active  = 0;
              m_done_at = cyc + 1;
            end
          end else begin
            m_und = 1;
          end
        end
      end else if (start && cyc > m_done_at) begin
        m_per = (ii == 0) ? 1 : int'(ii);
        m_rem = int'(count);
        m_und = 0;
        if (count == 0) begin
          m_done_at = cyc + 1;
        end else begin
          m_active = 1;
          m_next   = cyc + 1;
        end
      end
      m_done = (cyc == m_done_at);
      m_busy = act_pre || (cyc == m_done_at);
      if (in_valid && rdy_pre) mq.push_back(in_data);
      m_rdy = (mq.size() < D);
    end
  end

  function automatic logic [W+4:0] got_v();
    return {out_valid, done, busy, underrun, in_ready, out0};
  endfunction

  function automatic logic [W+4:0] exp_v();
    return {m_ov, m_done, m_busy, m_und, m_rdy, m_out0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    repeat (2) tick();
    tests++;
    if (got_v() !== '0) begin
      fails++;
      $display("FAIL reset_hold got=%h exp=0", got_v());
    end
    reset = 1'b1;
    tick();
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready got=%b exp=1", in_ready);
    end
    tests++;
    if (got_v() !== exp_v()) begin
      fails++;
      $display("FAIL reset_model got=%h exp=%h", got_v(), exp_v());
    end
  endtask

  task automatic test_basic();
    int nw = 0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = W'(32'hA + i);
      tick();
    end
    in_valid = 1'b0;
    tick();
    start = 1'b1; ii = 4'd2; count = 16'd3;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      tests++;
      if (got_v() !== exp_v()) begin
        fails++;
        $display("FAIL basic k=%0d got=%h exp=%h", k, got_v(), exp_v());
      end
      tests++;
      if (out_valid !== (k == 1 || k == 3 || k == 5)) begin
        fails++;
        $display("FAIL basic_ov k=%0d got=%b", k, out_valid);
      end
      if (out_valid === 1'b1) begin
        tests++;
        if (out0 !== W'(32'hA + nw)) begin
          fails++;
          $display("FAIL basic_data got=%h exp=%h", out0, 32'hA + nw);
        end
        nw++;
      end
      tests++;
      if (done !== (k == 6) || underrun !== 1'b0) begin
        fails++;
        $display("FAIL basic_done k=%0d got=%b/%b", k, done, underrun);
      end
    end
  endtask

  task automatic test_underrun();
    start = 1'b1; ii = 4'd1; count = 16'd2;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (k == 4) begin in_valid = 1'b1; in_data = 32'h11; end
      if (k == 5) in_data = 32'h22;
      if (k == 6) in_valid = 1'b0;
      tick();
      tests++;
      if (got_v() !== exp_v()) begin
        fails++;
        $display("FAIL under k=%0d got=%h exp=%h", k, got_v(), exp_v());
      end
      tests++;
      if (out_valid !== (k == 5 || k == 6) || done !== (k == 7) ||
          underrun !== 1'b1) begin
        fails++;
        $display("FAIL under_seq k=%0d got=%b%b%b", k, out_valid, done,
                 underrun);
      end
      if (k == 5 || k == 6) begin
        tests++;
        if (out0 !== ((k == 5) ? 32'h11 : 32'h22)) begin
          fails++;
          $display("FAIL under_data k=%0d got=%h", k, out0);
        end
      end
    end
  endtask

  task automatic test_count_zero();
    start = 1'b1; ii = 4'd1; count = 16'd0;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      tests++;
      if (got_v() !== exp_v() || busy !== (k == 1) ||
          done !== (k == 1) || out_valid !== 1'b0) begin
        fails++;
        $display("FAIL cnt0 k=%0d got=%h exp=%h", k, got_v(), exp_v());
      end
    end
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      tick();
    end
    in_valid = 1'b0;
    start = 1'b1; ii = 4'd0; count = 16'd2;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      tests++;
      if (got_v() !== exp_v() || out_valid !== (k <= 2) ||
          done !== (k == 3)) begin
        fails++;
        $display("FAIL ii0 k=%0d got=%h exp=%h", k, got_v(), exp_v());
      end
    end
  endtask

  task automatic test_start_ignored();
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      tick();
    end
    in_valid = 1'b0;
    start = 1'b1; ii = 4'd3; count = 16'd3;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      start    = (k == 2);
      ii       = 4'd1;
      count    = (k == 2) ? 16'd9 : 16'd3;
      in_valid = (k == 8);
      in_data  = $urandom;
      tick();
      tests++;
      if (got_v() !== exp_v() || done !== (k == 10) ||
          underrun !== (k >= 7)) begin
        fails++;
        $display("FAIL ignore k=%0d got=%h exp=%h", k, got_v(), exp_v());
      end
    end
    start = 1'b0; in_valid = 1'b0;
    start = 1'b1; count = 16'd0;
    tick();
    start = 1'b0;
    tick();
    tests++;
    if (underrun !== 1'b0 || done !== 1'b1) begin
      fails++;
      $display("FAIL restart_clear got=%b/%b exp=0/1", underrun, done);
    end
  endtask

  task automatic test_full_wrap();
    int nd = 0;
    int iss = 0;
    bit acc;
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      in_data  = W'(32'h100 + nd);
      acc = m_rdy;
      tick();
      if (acc) nd++;
      tests++;
      if (got_v() !== exp_v()) begin
        fails++;
        $display("FAIL fill k=%0d got=%h exp=%h", k, got_v(), exp_v());
      end
    end
    tests++;
    if (in_ready !== 1'b0 || nd != D) begin
      fails++;
      $display("FAIL full got=%b acc=%0d exp=0/%0d", in_ready, nd, D);
    end
    start = 1'b1; ii = 4'd1; count = 16'd20;
    for (int k = 0; k <= 22; k++) begin
      in_data = W'(32'h100 + nd);
      acc = m_rdy;
      tick();
      start = 1'b0;
      if (acc) nd++;
      tests++;
      if (got_v() !== exp_v()) begin
        fails++;
        $display("FAIL wrap k=%0d got=%h exp=%h", k, got_v(), exp_v());
      end
      if (k >= 1 && k <= 20) begin
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1 ||
            out0 !== W'(32'h100 + iss)) begin
          fails++;
          $display("FAIL wrap_seq k=%0d got=%b%b %h exp=%h", k, in_ready,
                   out_valid, out0, 32'h100 + iss);
        end
        iss++;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    start = 1'b1; ii = 4'd2; count = 16'd4;
    tick();
    start = 1'b0;
    tick();
    tests++;
    if (out_valid !== 1'b1) begin
      fails++;
      $display("FAIL mid_first got=%b exp=1", out_valid);
    end
    #2 reset = 1'b0;
    #1;
    tests++;
    if (got_v() !== '0) begin
      fails++;
      $display("FAIL mid_async got=%h exp=0", got_v());
    end
    tick();
    reset = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      tests++;
      if (got_v() !== exp_v() || done !== 1'b0) begin
        fails++;
        $display("FAIL mid_after k=%0d got=%h exp=%h", k, got_v(), exp_v());
      end
    end
    start = 1'b1; ii = 4'd1; count = 16'd1;
    tick();
    start = 1'b0;
    tick();
    tests++;
    if (underrun !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL mid_empty got=%b/%b exp=1/0", underrun, out_valid);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = $urandom;
      start    = ($urandom_range(0, 7) == 0);
      ii       = IIW'($urandom_range(0, 3));
      count    = CW'($urandom_range(0, 5));
      tick();
      tests++;
      if (got_v() !== exp_v()) begin
        fails++;
        $display("FAIL rand k=%0d got=%h exp=%h", k, got_v(), exp_v());
      end
    end
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_underrun();
    test_count_zero();
    test_start_ignored();
    test_full_wrap();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pe_stream_feeder.md
# pe_stream_feeder

Input-side stream feeder that sits directly upstream of a PE block's data input (e.g. `in0`) in the statically scheduled CGRA array. It buffers words arriving on a valid/ready bus in a small FIFO. Once started, it releases exactly `count` words onto the PE input at a fixed initiation interval (II), matching the compiled schedule. Starvation stalls the schedule and raises a sticky underrun flag instead of issuing stale data.

## Interface
Parameters:
- `size`, 32, data word width (matches PE `in0`/`in1`)
- `DEPTH`, 8, FIFO entries; power of two, ≥2
- `II_WIDTH`, 4, width of the II setting
- `CNT_WIDTH`, 16, width of the issue count

Ports:
- `clk`  in  1  single clock
- `reset`  in  1  asynchronous, active-low reset
- `in_data`  in  size  upstream word
- `in_valid`  in  1  upstream word present
- `in_ready`  out  1  FIFO can accept a word this cycle
- `start`  in  1  one-cycle pulse; begins a run (ignored unless idle)
- `ii`  in  II_WIDTH  issue period in cycles; sampled at `start`; 0 treated as 1
- `count`  in  CNT_WIDTH  words to issue this run; sampled at `start`
- `out0`  out  size  registered word to PE input; holds last issued value
- `out_valid`  out  1  one-cycle strobe on each issue
- `busy`  out  1  run in progress
- `done`  out  1  one-cycle pulse when the run completes
- `underrun`  out  1  sticky: an issue slot found the FIFO empty; cleared by `start`

## Operation
- **FIFO**
  - Push when `in_valid && in_ready`.
  - `in_ready = !full`. There is no same-cycle bypass.
  - Push and pop may occur in the same cycle. Occupancy is then unchanged.
  - Pointers wrap modulo `DEPTH`. Full and empty use a count or an extra pointer bit.
- **States:** IDLE, RUN, DONE.
- **IDLE**
  - `busy=0`.
  - On `start`: latch `period = max(ii,1)` and `remaining = count`, clear `underrun`, set `slot_cnt=0`.
  - If `count==0`, go to DONE. Otherwise go to RUN.
- **RUN**
  - `busy=1`.
  - Issue slot when `slot_cnt==0`:
    - If FIFO not empty: pop to `out0`, assert `out_valid`, decrement `remaining`, load `slot_cnt = period-1`.
    - If FIFO empty: set `underrun`, hold `slot_cnt=0` (stall), retry every cycle.
  - When `slot_cnt!=0`, decrement it.
  - Go to DONE in the cycle after the issue that makes `remaining` 0.
- **DONE**
  - `done=1` and `busy=1` for one cycle, then IDLE.
- `start` in RUN or DONE is ignored. The FIFO keeps accepting data in every state. Leftover words stay in the FIFO for the next run.
- **Reset (async, any time):** state IDLE, FIFO emptied, `out0=0`, `out_valid=0`, `done=0`, `busy=0`, `underrun=0`, `in_ready` low while reset is asserted and high after release.

## Timing
- `start` at cycle t (FIFO non-empty) gives the first `out_valid` at t+1.
- Subsequent issues at t+1+k·period when no stalls occur.
- A stall delays every later slot by the stall length. Period is measured from the last actual issue.
- A word pushed at cycle t is poppable at t+1.
- `done` asserts the cycle after the last `out_valid`.
- `count==0`: `done` at t+1, no `out_valid`.
- All outputs are registered. `out0` changes only on issue cycles.
- Reset mid-run aborts the run with no `done`.

## Structure
- Package `pe_stream_pkg`:
  - state enum (IDLE/RUN/DONE)
  - `II_WIDTH`/`CNT_WIDTH` defaults
  - `period` computation helper
- Sub-module `stream_fifo`: parameterised `size`/`DEPTH` synchronous FIFO with push/pop, `full`/`empty`, async active-low reset.
- The top level holds the FSM, `slot_cnt`, `remaining` and the output register.

## Test plan
- Preload 3 words (0xA, 0xB, 0xC), `start` with ii=2, count=3 -> `out_valid` at t+1, t+3, t+5 with 0xA/0xB/0xC; `done` at t+6; `underrun=0`.
- Empty FIFO, `start` with ii=1, count=2; push 0x11 at t+4 and 0x22 at t+5 -> issues at t+5 and t+6, `underrun=1` sticky, `done` at t+7.
- `start` with count=0 -> `done` at t+1, no `out_valid`, `busy` high for 1 cycle; `ii=0` with count=2 behaves as ii=1 (back-to-back issues).
- Fill FIFO to `DEPTH`=8 -> `in_ready=0`, ninth push refused. Simultaneous push and pop when at 7 entries -> occupancy stays 7 and wrap-around data order is preserved over 20 words.
- `start` pulsed during RUN -> ignored, and the original count completes. Then a new `start` clears `underrun`.
- Assert `reset` mid-run after 1 of 4 issues -> all outputs 0 immediately, no `done`, FIFO empty after release.
